// File: rtl/alarm_pkg.sv
// alarm_pkg: shared widths, state encoding and helpers for the alarm trigger block.
package alarm_pkg;

    localparam int HOUR_W    = 5;
    localparam int MIN_W     = 6;
    localparam int SEC_CNT_W = 9;

    localparam logic [SEC_CNT_W-1:0] SEC_CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RINGING   = 2'd1,
        ST_DISMISSED = 2'd2,
        ST_SNOOZE    = 2'd3
    } alarm_state_t;

    // States in which the shared second counter is allowed to run.
    function automatic logic is_timed(input alarm_state_t s);
        return (s == ST_RINGING) || (s == ST_SNOOZE);
    endfunction

endpackage

// File: rtl/alarm_sec_timer.sv
// alarm_sec_timer: clearable, tick-enabled saturating second counter with a
// terminal-value compare, shared by the ring timeout and the snooze interval.
module alarm_sec_timer
    import alarm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_tick,
    input  logic [SEC_CNT_W-1:0] i_terminal,
    output logic                 o_at_terminal
);

    logic [SEC_CNT_W-1:0] r_count;

    // Clear wins over a simultaneous tick; the count sticks at its maximum.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_tick && (r_count != SEC_CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_terminal = (r_count == i_terminal);

endmodule

// File: rtl/alarm_trigger.sv
// alarm_trigger: detects the alarm-time match and runs the ringing/dismiss state machine.
// Snooze support is compiled in only when the macro ALARM_SNOOZE_EN is defined.
module alarm_trigger
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic              blink_tick,
    input  logic [HOUR_W-1:0] time_hour,
    input  logic [MIN_W-1:0]  time_min,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MIN_W-1:0]  alarm_min,
    input  logic              alarm_en,
    input  logic              clock_running,
    input  logic              btn_dismiss,
    input  logic              btn_snooze,
    output logic              ringing,
    output logic              alarm_led,
    output logic              snoozing
);

    localparam logic [SEC_CNT_W-1:0] RING_TERM   = SEC_CNT_W'(RING_TIMEOUT_S - 1);
    localparam logic [SEC_CNT_W-1:0] SNOOZE_TERM = SEC_CNT_W'(SNOOZE_S - 1);

    alarm_state_t r_state;
    logic         r_qd;
    logic         r_ringing;
    logic         r_led;

    logic                 w_q;
    logic                 w_rise;
    logic                 w_abort;
    logic                 w_snoozeReq;
    logic                 w_toSnooze;
    logic                 w_wake;
    logic                 w_timerClear;
    logic                 w_timerTick;
    logic                 w_atTerm;
    logic [SEC_CNT_W-1:0] w_termValue;

    // Out-of-range time values are compared raw on purpose.
    assign w_q     = (time_hour == alarm_hour) && (time_min == alarm_min)
                     && alarm_en && clock_running;
    assign w_rise  = w_q && !r_qd;
    assign w_abort = !alarm_en || !clock_running;

`ifdef ALARM_SNOOZE_EN
    logic r_snoozing;
    assign w_snoozeReq = btn_snooze;
    assign snoozing    = r_snoozing;
`else
    logic w_unused_snooze;
    assign w_snoozeReq     = 1'b0;
    assign w_unused_snooze = btn_snooze;
    assign snoozing        = 1'b0;
`endif

    assign w_toSnooze = (r_state == ST_RINGING) && !w_abort && !btn_dismiss && w_snoozeReq;
    assign w_wake     = (r_state == ST_SNOOZE) && !w_abort && !btn_dismiss
                        && tick_1hz && w_atTerm;

    // The counter is held at zero outside the timed states, so every ring starts from 0.
    assign w_termValue  = (r_state == ST_SNOOZE) ? SNOOZE_TERM : RING_TERM;
    assign w_timerTick  = tick_1hz && is_timed(r_state);
    assign w_timerClear = !is_timed(r_state) || w_toSnooze || w_wake;

    alarm_sec_timer u_sec_timer (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (w_timerClear),
        .i_tick        (w_timerTick),
        .i_terminal    (w_termValue),
        .o_at_terminal (w_atTerm)
    );

    // Losing alarm_en or run mode beats every other exit from the timed states.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_qd      <= 1'b0;
            r_ringing <= 1'b0;
            r_led     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            r_snoozing <= 1'b0;
`endif
        end else begin
            r_qd <= w_q;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state   <= ST_RINGING;
                        r_ringing <= 1'b1;
                        r_led     <= 1'b1;
                    end
                end
                ST_RINGING: begin
                    if (w_abort) begin
                        r_state   <= ST_IDLE;
                        r_ringing <= 1'b0;
                        r_led     <= 1'b0;
                    end else if (btn_dismiss) begin
                        r_state   <= ST_DISMISSED;
                        r_ringing <= 1'b0;
                        r_led     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                    end else if (w_toSnooze) begin
                        r_state    <= ST_SNOOZE;
                        r_ringing  <= 1'b0;
                        r_led      <= 1'b0;
                        r_snoozing <= 1'b1;
`endif
                    end else if (tick_1hz && w_atTerm) begin
                        r_state   <= ST_DISMISSED;
                        r_ringing <= 1'b0;
                        r_led     <= 1'b0;
                    end else if (blink_tick) begin
                        r_led <= !r_led;
                    end
                end
                ST_DISMISSED: begin
                    if (!w_q) begin
                        r_state <= ST_IDLE;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                ST_SNOOZE: begin
                    if (w_abort) begin
                        r_state    <= ST_IDLE;
                        r_snoozing <= 1'b0;
                    end else if (btn_dismiss) begin
                        r_state    <= ST_DISMISSED;
                        r_snoozing <= 1'b0;
                    end else if (w_wake) begin
                        r_state    <= ST_RINGING;
                        r_snoozing <= 1'b0;
                        r_ringing  <= 1'b1;
                        r_led      <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state   <= ST_IDLE;
                    r_ringing <= 1'b0;
                    r_led     <= 1'b0;
                end
            endcase
        end
    end

    assign ringing   = r_ringing;
    assign alarm_led = r_led;

endmodule
